matrix_stream_ctrl: RTL and testbench
=====================================

// Module: matrix_stream_ctrl
// PURPOSE
//  Byte-stream front end for the matrix-multiply accelerator, parametrised in matrix order and element widths.
//  Takes UART RX bytes: one size byte, then A, then B (row-major), packed into flat operand buses.
//  Pulses the multiplier, waits for done under a timeout, then streams only the N*N result elements to UART TX.
//  Uses a ready/ack handshake. Reports bad size or timeout with an error byte.
// PARAMETERS
//  MAX_N    10     largest supported matrix order (1..16)
//  DW       8      operand element width, multiple of 8, <=32; EB=DW/8 bytes/element
//  RW       16     result element width, multiple of 8, <=64; RB=RW/8 bytes/element
//  TIMEOUT  4096   clk cycles allowed between mult_start and mult_done
//  ERR_BYTE 8'hEE  byte sent on size or timeout error
// PORTS
//  clk          in   1                 system clock (posedge)
//  rst          in   1                 synchronous, active-high reset
//  rx_data      in   8                 received byte
//  rx_valid     in   1                 1-cycle strobe, rx_data valid
//  tx_ready     in   1                 transmitter idle
//  tx_data      out  8                 byte to send, stable from tx_start until tx_ready returns high
//  tx_start     out  1                 1-cycle send request
//  mat_a        out  MAX_N*MAX_N*DW    operand A; element (r,c) at [(r*MAX_N+c)*DW +: DW]
//  mat_b        out  MAX_N*MAX_N*DW    operand B; same packing
//  mat_size     out  $clog2(MAX_N+1)   accepted order N
//  mult_start   out  1                 1-cycle start pulse to multiplier
//  mult_done    in   1                 multiplier completion strobe
//  mult_result  in   MAX_N*MAX_N*RW    product; same packing with RW
//  state        out  3                 current FSM state (debug/status)
//  err_flag     out  1                 sticky error; cleared when next valid size byte is accepted
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, mat_a/mat_b cleared, all counters 0.
//    Reset mid-operation aborts immediately. No byte is completed; tx_start is not raised again.
//  States: IDLE=0 LOAD_A=1 LOAD_B=2 COMPUTE=3 SEND=4 WAIT_ACK=5 WAIT_IDLE=6 ERR=7.
//  IDLE: on rx_valid, if 1<=rx_data<=MAX_N:
//    - mat_size<=rx_data
//    - mat_a, mat_b cleared, so unused positions read 0
//    - err_flag<=0, go LOAD_A.
//    Otherwise (0 or >MAX_N): err_flag<=1, go ERR.
//  LOAD_A/LOAD_B: each rx_valid stores one byte, little-endian within an element.
//    - Element index walks r=0..N-1, c=0..N-1 and maps to position r*MAX_N+c.
//    - After N*N*EB bytes move to the next state.
//    - The last B byte takes effect in the same cycle that mult_start is pulsed, then go COMPUTE.
//  COMPUTE: timeout counter runs from the cycle after mult_start.
//    - mult_done seen before TIMEOUT cycles: latch mult_result, go SEND.
//    - Counter reaches TIMEOUT: err_flag<=1, go ERR.
//    - mult_done outside COMPUTE is ignored.
//  SEND: when tx_ready=1, drive tx_data = next byte and pulse tx_start, go WAIT_ACK.
//    - Byte order: elements r-major over N*N only, RB bytes per element, LSB first.
//  WAIT_ACK: wait for tx_ready=0, then go WAIT_IDLE.
//  WAIT_IDLE: wait for tx_ready=1.
//    - Go SEND if bytes remain; after N*N*RB bytes go IDLE.
//  ERR: send ERR_BYTE using the same start/ack/idle handshake, then go IDLE.
//  Handshake rules:
//    - Never two tx_start pulses without an intervening tx_ready 0->1.
//    - tx_start is never issued while tx_ready=0.
//  rx_valid in COMPUTE/SEND/WAIT_*/ERR is dropped and does not affect counters.
//  Counters are sized for MAX_N*MAX_N*max(EB,RB) with no wrap. mat_size is never 0 after acceptance.
//  Latency: mult_start rises 1 cycle after the final B rx_valid. First tx_start is at least 1 cycle after mult_done.
// TESTING
//  1. N=2, A={1,2,3,4}, B={5,6,7,8}, model returns {19,22,43,50}.
//     -> mult_start once; TX bytes 13 00 16 00 2B 00 32 00; then IDLE.
//  2. Size byte 0x00, then 0x0B (MAX_N=10).
//     -> each gives err_flag=1 and one ERR_BYTE 0xEE; no mult_start.
//  3. Valid N=3 load, mult_done withheld.
//     -> err_flag after exactly TIMEOUT cycles, 0xEE sent, back to IDLE.
//  4. tx_ready held low 50 cycles during SEND.
//     -> no tx_start while low; tx_data stable; no byte lost or duplicated.
//  5. rst asserted after 5 bytes of A.
//     -> next cycle state=0, mat_a=0; a fresh N=1 run gives correct product.
//  6. N=MAX_N with all elements 0xFF.
//     -> mat_a/mat_b fully populated; exactly 200 TX bytes for RW=16.

Source files
------------

// File: rtl/matrix_stream_ctrl_if.sv
// Signal bundle between the matrix stream controller and its environment:
// UART byte streams, multiplier control and the flat operand/result buses.
interface matrix_stream_ctrl_if #(
  parameter int MAX_N = 10,
  parameter int DW    = 8,
  parameter int RW    = 16
);
  localparam int SW = $clog2(MAX_N + 1);

  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      tx_ready;
  logic [7:0]                tx_data;
  logic                      tx_start;
  logic [MAX_N*MAX_N*DW-1:0] mat_a;
  logic [MAX_N*MAX_N*DW-1:0] mat_b;
  logic [SW-1:0]             mat_size;
  logic                      mult_start;
  logic                      mult_done;
  logic [MAX_N*MAX_N*RW-1:0] mult_result;

  // Controller side
  modport slave (
    input  rx_data, rx_valid, tx_ready, mult_done, mult_result,
    output tx_data, tx_start, mat_a, mat_b, mat_size, mult_start
  );

  // Environment side (UART and multiplier)
  modport master (
    output rx_data, rx_valid, tx_ready, mult_done, mult_result,
    input  tx_data, tx_start, mat_a, mat_b, mat_size, mult_start
  );
endinterface

// File: rtl/matrix_stream_ctrl.sv
// Byte-stream front end for the matrix-multiply accelerator.
// Receives a size byte followed by A and B (row-major, little-endian elements),
// starts the multiplier, waits for completion under a timeout and streams the
// N*N result elements back over a start/ack/idle transmit handshake.
module matrix_stream_ctrl #(
  parameter int         MAX_N    = 10,
  parameter int         DW       = 8,
  parameter int         RW       = 16,
  parameter int         TIMEOUT  = 4096,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic                       clk,
  input  logic                       rst,
  matrix_stream_ctrl_if.slave        bus,
  output logic [2:0]                 state,
  output logic                       err_flag
);
  localparam int EB   = DW / 8;
  localparam int RB   = RW / 8;
  localparam int NPOS = MAX_N * MAX_N;
  localparam int SW   = $clog2(MAX_N + 1);
  localparam int PW   = $clog2(NPOS + 1);
  localparam int BMAX = (EB > RB) ? EB : RB;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int AW   = $clog2(NPOS * DW);
  localparam int RAW  = $clog2(NPOS * RW);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_COMPUTE   = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_ACK  = 3'd5,
    S_WAIT_IDLE = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  state_t              state_reg;
  logic [NPOS*DW-1:0]  mat_a_reg;
  logic [NPOS*DW-1:0]  mat_b_reg;
  logic [NPOS*RW-1:0]  result_reg;
  logic [SW-1:0]       size_reg;
  logic [SW-1:0]       row_reg;
  logic [SW-1:0]       col_reg;
  logic [PW-1:0]       row_base_reg;
  logic [BW-1:0]       bsel_reg;
  logic [TW-1:0]       timer_reg;
  logic [7:0]          tx_data_reg;
  logic                tx_start_reg;
  logic                mult_start_reg;
  logic                err_reg;
  logic                err_send_reg;
  logic                last_sent_reg;

  logic [PW-1:0]       pos;
  logic [AW-1:0]       wr_bit;
  logic [RAW-1:0]      rd_bit;
  logic                last_byte;
  logic                last_col;
  logic                last_row;
  logic                last_all;
  logic [BW-1:0]       bsel_next;
  logic [SW-1:0]       col_next;
  logic [SW-1:0]       row_next;
  logic [PW-1:0]       row_base_next;
  logic                size_ok;

  // Element walker: current packed position, byte offsets and the next step
  // of the (row, col, byte) walk shared by loading and sending.
  always_comb begin
    pos       = row_base_reg + PW'(col_reg);
    wr_bit    = AW'(pos) * AW'(DW) + (AW'(bsel_reg) << 3);
    rd_bit    = RAW'(pos) * RAW'(RW) + (RAW'(bsel_reg) << 3);
    last_byte = (state_reg == S_SEND) ? (bsel_reg == BW'(RB - 1))
                                      : (bsel_reg == BW'(EB - 1));
    last_col  = (col_reg == size_reg - SW'(1));
    last_row  = (row_reg == size_reg - SW'(1));
    last_all  = last_byte && last_col && last_row;
    size_ok   = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_N));

    bsel_next     = bsel_reg + BW'(1);
    col_next      = col_reg;
    row_next      = row_reg;
    row_base_next = row_base_reg;
    if (last_byte) begin
      bsel_next = '0;
      if (last_col) begin
        col_next      = '0;
        row_next      = row_reg + SW'(1);
        row_base_next = row_base_reg + PW'(MAX_N);
      end else begin
        col_next = col_reg + SW'(1);
      end
    end
  end

  // Main controller FSM with registered outputs; a reset aborts any
  // transfer in progress and clears the operand buses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      mat_a_reg      <= '0;
      mat_b_reg      <= '0;
      result_reg     <= '0;
      size_reg       <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      row_base_reg   <= '0;
      bsel_reg       <= '0;
      timer_reg      <= '0;
      tx_data_reg    <= '0;
      tx_start_reg   <= 1'b0;
      mult_start_reg <= 1'b0;
      err_reg        <= 1'b0;
      err_send_reg   <= 1'b0;
      last_sent_reg  <= 1'b0;
    end else begin
      mult_start_reg <= 1'b0;
      tx_start_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.rx_valid) begin
            row_reg      <= '0;
            col_reg      <= '0;
            row_base_reg <= '0;
            bsel_reg     <= '0;
            if (size_ok) begin
              size_reg  <= bus.rx_data[SW-1:0];
              mat_a_reg <= '0;
              mat_b_reg <= '0;
              err_reg   <= 1'b0;
              state_reg <= S_LOAD_A;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_ERR;
            end
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          if (bus.rx_valid) begin
            if (state_reg == S_LOAD_A) begin
              mat_a_reg[wr_bit +: 8] <= bus.rx_data;
            end else begin
              mat_b_reg[wr_bit +: 8] <= bus.rx_data;
            end
            if (last_all) begin
              row_reg      <= '0;
              col_reg      <= '0;
              row_base_reg <= '0;
              bsel_reg     <= '0;
              if (state_reg == S_LOAD_A) begin
                state_reg <= S_LOAD_B;
              end else begin
                // Final B byte lands together with the start pulse.
                mult_start_reg <= 1'b1;
                timer_reg      <= '0;
                state_reg      <= S_COMPUTE;
              end
            end else begin
              row_reg      <= row_next;
              col_reg      <= col_next;
              row_base_reg <= row_base_next;
              bsel_reg     <= bsel_next;
            end
          end
        end

        S_COMPUTE: begin
          if (bus.mult_done) begin
            result_reg    <= bus.mult_result;
            last_sent_reg <= 1'b0;
            state_reg     <= S_SEND;
          end else if (!mult_start_reg) begin
            // The start cycle itself is not counted.
            if (timer_reg == TW'(TIMEOUT - 1)) begin
              err_reg   <= 1'b1;
              state_reg <= S_ERR;
            end else begin
              timer_reg <= timer_reg + TW'(1);
            end
          end
        end

        S_SEND: begin
          if (bus.tx_ready) begin
            tx_data_reg   <= result_reg[rd_bit +: 8];
            tx_start_reg  <= 1'b1;
            last_sent_reg <= last_all;
            row_reg       <= row_next;
            col_reg       <= col_next;
            row_base_reg  <= row_base_next;
            bsel_reg      <= bsel_next;
            state_reg     <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (!bus.tx_ready) begin
            state_reg <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (bus.tx_ready) begin
            if (err_send_reg || last_sent_reg) begin
              err_send_reg  <= 1'b0;
              last_sent_reg <= 1'b0;
              row_reg       <= '0;
              col_reg       <= '0;
              row_base_reg  <= '0;
              bsel_reg      <= '0;
              state_reg     <= S_IDLE;
            end else begin
              state_reg <= S_SEND;
            end
          end
        end

        S_ERR: begin
          if (bus.tx_ready) begin
            tx_data_reg  <= ERR_BYTE;
            tx_start_reg <= 1'b1;
            err_send_reg <= 1'b1;
            state_reg    <= S_WAIT_ACK;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_start   = tx_start_reg;
  assign bus.mat_a      = mat_a_reg;
  assign bus.mat_b      = mat_b_reg;
  assign bus.mat_size   = size_reg;
  assign bus.mult_start = mult_start_reg;
  assign state          = state_reg;
  assign err_flag       = err_reg;
endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Self-checking bench for matrix_stream_ctrl: table of vectors plus random
// runs, a UART transmitter responder and a behavioural matrix product model.
module tb_matrix_stream_ctrl;
  localparam int         MAX_N    = 10;
  localparam int         DW       = 8;
  localparam int         RW       = 16;
  localparam int         TIMEOUT  = 4096;
  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam int         EB       = DW / 8;
  localparam int         RB       = RW / 8;
  localparam int         NPOS     = MAX_N * MAX_N;

  localparam int M_RAND    = 0;
  localparam int M_FIXED   = 1;
  localparam int M_FF      = 2;
  localparam int M_TIMEOUT = 3;
  localparam int M_BADSIZE = 4;
  localparam int M_HOLD    = 5;

  typedef struct {
    string name;
    int    size_byte;
    int    mode;
    int    done_delay;
    int    exp_err;
    int    exp_bytes;
    int    exp_starts;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       err_flag;

  matrix_stream_ctrl_if #(.MAX_N(MAX_N), .DW(DW), .RW(RW)) bus ();

  matrix_stream_ctrl #(
    .MAX_N(MAX_N), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT), .ERR_BYTE(ERR_BYTE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state(state),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  int         mult_start_cnt = 0;
  int         hold_arm = 0;
  int         tx_max_busy = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int sz, input int md, input int dd,
                              input int ee, input int eb, input int es);
    vec_t v;
    v.name = nm; v.size_byte = sz; v.mode = md; v.done_delay = dd;
    v.exp_err = ee; v.exp_bytes = eb; v.exp_starts = es;
    return v;
  endfunction

  // UART transmitter model: captures bytes, drops tx_ready for a while after
  // each start, and optionally holds tx_ready low for 50 cycles in SEND.
  task automatic tx_side();
    int         busy = 0;
    int         hold = 0;
    logic [7:0] cap = 8'h00;
    bit         pending = 1'b0;
    bit         stable_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.mult_start === 1'b1) mult_start_cnt++;
      if (bus.tx_start === 1'b1) check("tx_start_needs_ready", bus.tx_ready, 1);
      if (rst === 1'b1) begin
        bus.tx_ready = 1'b1; busy = 0; hold = 0; pending = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          check("hold_keeps_send", state, 3'd4);
          bus.tx_ready = 1'b1;
        end
      end else if (bus.tx_start === 1'b1) begin
        tx_q.push_back(bus.tx_data);
        $display("tx byte %02h (#%0d)", bus.tx_data, tx_q.size());
        cap = bus.tx_data; pending = 1'b1; stable_ok = 1'b1;
        bus.tx_ready = 1'b0;
        busy = $urandom_range(tx_max_busy, 0);
      end else if (pending) begin
        if (bus.tx_data !== cap) stable_ok = 1'b0;
        if (busy > 0) busy--;
        else begin
          bus.tx_ready = 1'b1;
          pending = 1'b0;
          check("tx_data_stable", stable_ok, 1);
        end
      end else if (hold_arm != 0 && state == 3'd4 && bus.tx_ready === 1'b1) begin
        hold_arm = 0;
        hold = 50;
        bus.tx_ready = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  // Run one frame: size byte, A, B, multiplier response, then collect TX.
  task automatic run_vector(input vec_t v);
    logic [63:0]        a [MAX_N][MAX_N];
    logic [63:0]        b [MAX_N][MAX_N];
    logic [NPOS*DW-1:0] exp_a;
    logic [NPOS*DW-1:0] exp_b;
    logic [NPOS*RW-1:0] res;
    logic [63:0]        acc;
    logic [63:0]        mask;
    logic [7:0]         exp_q[$];
    int                 n, base_starts, nbad, cyc, k;
    bit                 noisy;

    n = v.size_byte;
    noisy = (v.mode == M_HOLD);
    tx_q.delete();
    base_starts = mult_start_cnt;
    tx_max_busy = $urandom_range(3, 0);
    exp_a = '0;
    exp_b = '0;
    mask = (64'd1 << DW) - 64'd1;

    gap();
    send_byte(8'(v.size_byte));
    if (v.mode == M_BADSIZE) begin
      exp_q.push_back(ERR_BYTE);
    end else begin
      check({v.name, "_mat_size"}, bus.mat_size, n);
      check({v.name, "_err_cleared"}, err_flag, 0);
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          if (v.mode == M_FIXED) begin
            a[r][c] = 64'(r * n + c + 1);
            b[r][c] = 64'(r * n + c + 5);
          end else if (v.mode == M_FF) begin
            a[r][c] = mask;
            b[r][c] = mask;
          end else begin
            a[r][c] = {32'($urandom), 32'($urandom)} & mask;
            b[r][c] = {32'($urandom), 32'($urandom)} & mask;
          end
          exp_a[(r*MAX_N+c)*DW +: DW] = a[r][c][DW-1:0];
          exp_b[(r*MAX_N+c)*DW +: DW] = b[r][c][DW-1:0];
        end
      end
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++)
          for (int i = 0; i < EB; i++) begin
            gap();
            send_byte(a[r][c][8*i +: 8]);
          end
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++)
          for (int i = 0; i < EB; i++) begin
            gap();
            send_byte(b[r][c][8*i +: 8]);
          end
      check({v.name, "_mult_start_latency"}, bus.mult_start, 1);

      nbad = 0;
      for (int p = 0; p < NPOS; p++) begin
        if (bus.mat_a[p*DW +: DW] !== exp_a[p*DW +: DW]) nbad++;
        if (bus.mat_b[p*DW +: DW] !== exp_b[p*DW +: DW]) nbad++;
      end
      check({v.name, "_operand_elems_bad"}, nbad, 0);

      if (v.mode == M_TIMEOUT) begin
        // First counted cycle follows mult_start; err_flag shows TIMEOUT cycles later.
        k = 0;
        while (err_flag !== 1'b1 && k < TIMEOUT + 20) begin
          @(negedge clk);
          k++;
        end
        check({v.name, "_timeout_cycles"}, k, TIMEOUT + 1);
        exp_q.push_back(ERR_BYTE);
      end else begin
        for (int i = 0; i < NPOS * RW / 8; i++) res[i*8 +: 8] = 8'($urandom);
        for (int r = 0; r < n; r++)
          for (int c = 0; c < n; c++) begin
            acc = 64'd0;
            for (int j = 0; j < n; j++) acc = acc + a[r][j] * b[j][c];
            res[(r*MAX_N+c)*RW +: RW] = acc[RW-1:0];
            for (int i = 0; i < RB; i++) exp_q.push_back(acc[8*i +: 8]);
          end
        repeat (v.done_delay) @(negedge clk);
        if (noisy) hold_arm = 1;
        bus.mult_result = res;
        bus.mult_done = 1'b1;
        @(negedge clk);
        bus.mult_done = 1'b0;
        for (int i = 0; i < NPOS * RW / 8; i++) bus.mult_result[i*8 +: 8] = 8'($urandom);
      end
    end

    cyc = 0;
    while (!(tx_q.size() >= v.exp_bytes && state == 3'd0 && bus.tx_ready === 1'b1) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (noisy && state >= 3'd3 && $urandom_range(2, 0) == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'($urandom_range(MAX_N, 1));
      end else begin
        bus.rx_valid = 1'b0;
      end
    end
    bus.rx_valid = 1'b0;
    check({v.name, "_completed_in_time"}, cyc < 6000, 1);
    repeat (4) @(negedge clk);

    check({v.name, "_tx_count"}, tx_q.size(), v.exp_bytes);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) nbad++;
    check({v.name, "_tx_bytes_bad"}, nbad, 0);
    check({v.name, "_mult_starts"}, mult_start_cnt - base_starts, v.exp_starts);
    check({v.name, "_err_flag"}, err_flag, v.exp_err);
    check({v.name, "_state_idle"}, state, 3'd0);
    $display("vector %s n=%0d tx=%0d starts=%0d err=%0b", v.name, n, tx_q.size(),
             mult_start_cnt - base_starts, err_flag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    int   n;

    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.mult_done = 1'b0;
    bus.mult_result = '0;
    bus.tx_ready = 1'b1;
    fork
      tx_side();
    join_none

    repeat (3) @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_err_flag", err_flag, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_mult_start", bus.mult_start, 0);
    check("rst_mat_size", bus.mat_size, 0);
    check("rst_mat_a_zero", bus.mat_a == '0, 1);
    check("rst_mat_b_zero", bus.mat_b == '0, 1);
    rst = 1'b0;
    @(negedge clk);

    // mult_done while idle must be ignored
    bus.mult_result = {NPOS*RW/32{32'hA5A5_5A5A}};
    bus.mult_done = 1'b1;
    @(negedge clk);
    bus.mult_done = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_done_state", state, 3'd0);
    check("stray_done_tx", tx_q.size(), 0);

    // Reset in the middle of loading A
    send_byte(8'd3);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 9));
    check("pre_rst_state_load_a", state, 3'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_mat_a_zero", bus.mat_a == '0, 1);
    check("mid_rst_mat_size", bus.mat_size, 0);
    check("mid_rst_tx_start", bus.tx_start, 0);
    rst = 1'b0;
    @(negedge clk);

    tbl.push_back(mk("n1_after_rst", 1,  M_RAND,    2, 0, 1 * RB,     1));
    tbl.push_back(mk("t1_n2_fixed",  2,  M_FIXED,   3, 0, 4 * RB,     1));
    tbl.push_back(mk("bad_size_00",  0,  M_BADSIZE, 0, 1, 1,          0));
    tbl.push_back(mk("bad_size_0b",  11, M_BADSIZE, 0, 1, 1,          0));
    tbl.push_back(mk("n3_timeout",   3,  M_TIMEOUT, 0, 1, 1,          1));
    tbl.push_back(mk("n4_hold",      4,  M_HOLD,    5, 0, 16 * RB,    1));
    tbl.push_back(mk("n10_all_ff",   10, M_FF,      2, 0, NPOS * RB,  1));
    tbl.push_back(mk("n5_rand",      5,  M_RAND,    7, 0, 25 * RB,    1));
    tbl.push_back(mk("n2_done_now",  2,  M_RAND,    0, 0, 4 * RB,     1));
    for (int i = 0; i < tbl.size(); i++) run_vector(tbl[i]);

    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(MAX_N, 1);
      run_vector(mk($sformatf("rand%0d_n%0d", i, n), n, (i == 2) ? M_HOLD : M_RAND,
                    $urandom_range(20, 0), 0, n * n * RB, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
